// File: rtl/bit_serial_pkg.sv
// Shared opcode and state encodings for the bit-serial ALU sequencer.
package bit_serial_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/bit_serial_alu_slice.sv
// Combinational 1-bit ALU slice; SUB arrives with b pre-inverted and cin preset, so it reuses the adder.
module bit_serial_alu_slice
  import bit_serial_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       res_bit,
  output logic       cout
);

  always_comb begin
    res_bit = 1'b0;
    cout    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        res_bit = a ^ b ^ cin;
        cout    = (a & b) | (a & cin) | (b & cin);
      end
      OP_AND: res_bit = a & b;
      OP_XOR: res_bit = a ^ b;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu_sequencer.sv
// Bit-serial execute sequencer: accepts a parallel operand pair, shifts it LSB-first through
// a 1-bit ALU slice for WIDTH cycles, then holds the assembled result and flags until taken.
module bit_serial_alu_sequencer
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     carry_out,
  output logic                     zero,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] sha, shb;
  logic             carry;
  logic [1:0]       op_q;
  logic             zacc;
  logic             accept, last;
  logic             slice_bit, slice_cout;

  bit_serial_alu_slice u_slice (
    .a       (sha[0]),
    .b       (shb[0]),
    .cin     (carry),
    .op      (op_q),
    .res_bit (slice_bit),
    .cout    (slice_cout)
  );

  assign start_ready = (state == ST_IDLE);

  // Next-state decode plus the accept / final-bit strobes used by the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_valid) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_idx == LAST_IDX) begin
          last       = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Shift registers, carry flop, bit counter and registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sha       <= '0;
      shb       <= '0;
      carry     <= 1'b0;
      op_q      <= OP_ADD;
      zacc      <= 1'b0;
      bit_idx   <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_valid <= (state_next == ST_HOLD);
      busy      <= (state_next != ST_IDLE);
      if (accept) begin
        sha     <= a;
        shb     <= (op == OP_SUB) ? ~b : b;
        carry   <= (op == OP_SUB);
        op_q    <= op;
        bit_idx <= '0;
        zacc    <= 1'b0;
      end else if (state == ST_SHIFT) begin
        result  <= {slice_bit, result[WIDTH-1:1]};
        sha     <= sha >> 1;
        shb     <= shb >> 1;
        carry   <= slice_cout;
        zacc    <= zacc | slice_bit;
        bit_idx <= last ? '0 : bit_idx + IDX_W'(1);
        if (last) begin
          carry_out <= slice_cout;
          zero      <= ~(zacc | slice_bit);
        end
      end
    end
  end

endmodule
